// File: rtl/bus_drvr_fifo_if.sv
// Handshake bundle between the device/agent side and the per-driver bus FIFO.
// Widths follow the FIFO parameters so that one instance matches one FIFO.
interface bus_drvr_fifo_if #(
  parameter int unsigned pckg_sz = 16,
  parameter int unsigned depth   = 8
);
  localparam int unsigned CW = $clog2(depth) + 1;

  logic               wr_en;
  logic [pckg_sz-1:0] wr_data;
  logic               full;
  logic               almost_full;
  logic               pop;
  logic               pndng;
  logic [pckg_sz-1:0] D_pop;
  logic [CW-1:0]      count;
  logic               overflow;
  logic               underflow;
  logic               clr_flags;

  modport master (
    output wr_en, wr_data, pop, clr_flags,
    input  full, almost_full, pndng, D_pop, count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, pop, clr_flags,
    output full, almost_full, pndng, D_pop, count, overflow, underflow
  );
endinterface

// File: rtl/bus_drvr_fifo.sv
// First-word-fall-through input FIFO feeding one bus driver slot.
// Define BUS_DRVR_FIFO_DROP_OLDEST_EN to drop the oldest entry on a write while full.
module bus_drvr_fifo #(
  parameter int unsigned pckg_sz        = 16,
  parameter int unsigned depth          = 8,
  parameter int unsigned almost_full_th = 6
) (
  input  logic             clk,
  input  logic             reset,
  bus_drvr_fifo_if.slave   bus
);
  localparam int unsigned AW = $clog2(depth);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] AF_TH_C = CW'(almost_full_th);

  logic [pckg_sz-1:0] mem_q [depth];
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, full_d;
  logic               almost_full_q, almost_full_d;
  logic               pndng_q, pndng_d;
  logic               overflow_q, overflow_d;
  logic               underflow_q, underflow_d;

  logic eff_pop;
  logic do_write;
  logic do_read;
  logic ovf_evt;
  logic udf_evt;

  always_comb begin
    eff_pop  = bus.pop && (count_q != '0);
    udf_evt  = bus.pop && (count_q == '0);
    do_write = 1'b0;
    do_read  = eff_pop;
    ovf_evt  = 1'b0;
    if (bus.wr_en) begin
      if (!full_q || eff_pop) begin
        do_write = 1'b1;
      end else begin
        ovf_evt = 1'b1;
`ifdef BUS_DRVR_FIFO_DROP_OLDEST_EN
        // retire the head and store the new packet in the freed slot
        do_write = 1'b1;
        do_read  = 1'b1;
`endif
      end
    end

    wr_ptr_d = do_write ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_read  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    count_d = count_q;
    if (do_write && !do_read) begin
      count_d = count_q + CW'(1);
    end else if (!do_write && do_read) begin
      count_d = count_q - CW'(1);
    end

    // status flags are registered from the next-state fill level
    full_d        = (count_d == DEPTH_C);
    almost_full_d = (count_d >= AF_TH_C);
    pndng_d       = (count_d != '0);

    // a new error event on the same edge as clr_flags keeps the flag set
    overflow_d  = (overflow_q  && !bus.clr_flags) || ovf_evt;
    underflow_d = (underflow_q && !bus.clr_flags) || udf_evt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      pndng_q       <= 1'b0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      full_q        <= full_d;
      almost_full_q <= almost_full_d;
      pndng_q       <= pndng_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_write) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.D_pop       = pndng_q ? mem_q[rd_ptr_q] : '0;
  assign bus.count       = count_q;
  assign bus.full        = full_q;
  assign bus.almost_full = almost_full_q;
  assign bus.pndng       = pndng_q;
  assign bus.overflow    = overflow_q;
  assign bus.underflow   = underflow_q;
endmodule

// File: tb/tb_bus_drvr_fifo.sv
// Self-checking bench for bus_drvr_fifo: directed scenarios plus random traffic
// compared against a queue-based model of the FIFO's externally visible behaviour.
module tb_bus_drvr_fifo;
  localparam int unsigned PW = 16;
  localparam int unsigned DEP = 4;
  localparam int unsigned AFT = 3;
`ifdef BUS_DRVR_FIFO_DROP_OLDEST_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  bus_drvr_fifo_if #(.pckg_sz(PW), .depth(DEP)) bif ();

  bus_drvr_fifo #(.pckg_sz(PW), .depth(DEP), .almost_full_th(AFT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [PW-1:0] mq[$];
  bit m_ovf;
  bit m_udf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Apply the inputs present at this edge to the model.
  task automatic model_edge();
    bit popok, ovf_ev, udf_ev;
    popok  = bif.pop && (mq.size() > 0);
    udf_ev = bif.pop && (mq.size() == 0);
    ovf_ev = 1'b0;
    if (bif.wr_en) begin
      if (mq.size() < DEP || popok) begin
        if (popok) void'(mq.pop_front());
        mq.push_back(bif.wr_data);
      end else begin
        ovf_ev = 1'b1;
        if (DROP) begin
          void'(mq.pop_front());
          mq.push_back(bif.wr_data);
        end
      end
    end else if (popok) begin
      void'(mq.pop_front());
    end
    m_ovf = ovf_ev || (m_ovf && !bif.clr_flags);
    m_udf = udf_ev || (m_udf && !bif.clr_flags);
  endtask

  task automatic check_all();
    chk("pndng",       32'(bif.pndng),       32'(mq.size() != 0));
    chk("D_pop",       32'(bif.D_pop),       (mq.size() != 0) ? 32'(mq[0]) : 32'h0);
    chk("count",       32'(bif.count),       32'(mq.size()));
    chk("full",        32'(bif.full),        32'(mq.size() == DEP));
    chk("almost_full", 32'(bif.almost_full), 32'(mq.size() >= AFT));
    chk("overflow",    32'(bif.overflow),    32'(m_ovf));
    chk("underflow",   32'(bif.underflow),   32'(m_udf));
  endtask

  task automatic drive(input bit w, input logic [PW-1:0] d, input bit p, input bit c);
    bif.wr_en     = w;
    bif.wr_data   = d;
    bif.pop       = p;
    bif.clr_flags = c;
  endtask

  // Called at a negedge with inputs set: clock once, update model, compare.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic fill_1_to_4();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, PW'(i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [PW-1:0] exp_d;
    drive(1'b0, '0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_all();

    // First write: nothing visible before the edge, head visible after.
    drive(1'b1, 16'h00A1, 1'b0, 1'b0);
    chk("pre_wr_pndng", 32'(bif.pndng), 32'h0);
    chk("pre_wr_dpop",  32'(bif.D_pop), 32'h0);
    step();
    chk("wr_dpop",  32'(bif.D_pop), 32'h00A1);
    chk("wr_count", 32'(bif.count), 32'h1);
    drive(1'b0, '0, 1'b1, 1'b0);
    step();

    // Fill and drain.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, PW'(i), 1'b0, 1'b0);
      step();
      if (i == 3) chk("af_at_3", 32'(bif.almost_full), 32'h1);
    end
    chk("full_at_4",  32'(bif.full),  32'h1);
    chk("count_at_4", 32'(bif.count), 32'h4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_dpop", 32'(bif.D_pop), 32'(i));
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    chk("drained_pndng", 32'(bif.pndng), 32'h0);
    chk("drained_dpop",  32'(bif.D_pop), 32'h0);

    // Write plus pop while full, then drain across the pointer wrap.
    fill_1_to_4();
    drive(1'b1, 16'h0005, 1'b1, 1'b0);
    step();
    chk("wp_full_count", 32'(bif.count),    32'h4);
    chk("wp_full_dpop",  32'(bif.D_pop),    32'h2);
    chk("wp_full_ovf",   32'(bif.overflow), 32'h0);
    for (int i = 2; i <= 5; i++) begin
      chk("wrap_dpop", 32'(bif.D_pop), 32'(i));
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end

    // Write while full without pop.
    fill_1_to_4();
    drive(1'b1, 16'h00FF, 1'b0, 1'b0);
    step();
    chk("ovf_set", 32'(bif.overflow), 32'h1);
    chk("ovf_dpop", 32'(bif.D_pop), DROP ? 32'h2 : 32'h1);
    for (int i = 0; i < 4; i++) begin
      if (DROP) exp_d = (i == 3) ? 16'h00FF : PW'(i + 2);
      else      exp_d = PW'(i + 1);
      chk("ovf_drain", 32'(bif.D_pop), 32'(exp_d));
      drive(1'b0, '0, 1'b1, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    chk("ovf_clr", 32'(bif.overflow), 32'h0);

    // Underflow, write+pop on empty, clear.
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    chk("udf_set",   32'(bif.underflow), 32'h1);
    chk("udf_count", 32'(bif.count),     32'h0);
    drive(1'b1, 16'h0BEE, 1'b1, 1'b0);
    step();
    chk("wp_empty_count", 32'(bif.count), 32'h1);
    chk("wp_empty_dpop",  32'(bif.D_pop), 32'h0BEE);
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    chk("udf_clr", 32'(bif.underflow), 32'h0);
    // clr and a fresh underflow on the same edge: flag stays set
    drive(1'b0, '0, 1'b1, 1'b0);
    step();
    drive(1'b0, '0, 1'b1, 1'b1);
    step();
    chk("udf_set_wins", 32'(bif.underflow), 32'h1);

    // Asynchronous reset between edges with three entries queued.
    drive(1'b0, '0, 1'b0, 1'b1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, PW'(16'h0100 + i), 1'b0, 1'b0);
      step();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(bif.count), 32'h3);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("arst_pndng", 32'(bif.pndng), 32'h0);
    chk("arst_count", 32'(bif.count), 32'h0);
    chk("arst_full",  32'(bif.full),  32'h0);
    chk("arst_dpop",  32'(bif.D_pop), 32'h0);
    #1 reset = 1'b0;
    @(negedge clk);
    check_all();

    // Random traffic in phases biased toward filling and draining.
    for (int n = 0; n < 600; n++) begin
      int unsigned wp, pp;
      wp = ((n / 50) % 2 == 0) ? 75 : 30;
      pp = ((n / 50) % 2 == 0) ? 30 : 75;
      drive($urandom_range(99) < wp, PW'($urandom), $urandom_range(99) < pp,
            $urandom_range(15) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_drvr_fifo.md
Name: bus_drvr_fifo

Overview:
- Per-driver input FIFO directly upstream of the bus DUT; one instance per (bit, driver) slot.
- Device/agent side writes packets in; the bus side sees pndng/D_pop and consumes packets with pop.
- First-word-fall-through: the head packet is always visible on D_pop while pndng is high.

Parameters:
pckg_sz, 16, packet width in bits (matches bus packet width)
depth, 8, FIFO entries; power of two, minimum 2
almost_full_th, 6, fill level at which almost_full asserts (1..depth)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
wr_en  input  1  write request from device/agent side
wr_data  input  pckg_sz  packet to enqueue
full  output  1  count == depth
almost_full  output  1  count >= almost_full_th
pop  input  1  bus consumes head packet
pndng  output  1  FIFO non-empty (packet pending for bus)
D_pop  output  pckg_sz  head packet; 0 when empty
count  output  $clog2(depth)+1  current fill level
overflow  output  1  sticky: write lost or packet dropped
underflow  output  1  sticky: pop while empty
clr_flags  input  1  synchronous clear of overflow/underflow

Behaviour:
- Reset (async, active-high): rd_ptr=0, wr_ptr=0, count=0, pndng=0, full=0, almost_full=0, overflow=0, underflow=0, D_pop=0. Memory contents are not reset. Reset asserted mid-operation discards all entries immediately.
- count, full, almost_full and pndng are registered and derived from the next-state count. A write at edge N makes pndng=1 after edge N. Write-to-D_pop latency is 1 cycle.
- D_pop = mem[rd_ptr] when count!=0, else 0. It is combinational from the registered pointer and memory.
- Pointers are $clog2(depth) bits and wrap naturally from depth-1 to 0.
- Per-edge cases, with eff_pop = pop && count!=0:
  - wr only, not full: write mem[wr_ptr], wr_ptr++, count++.
  - eff_pop only: rd_ptr++, count--.
  - wr and eff_pop, any level including full: both happen, count unchanged, no overflow.
  - wr and pop when empty: write happens, count becomes 1, underflow sets.
  - pop when empty (no wr): state unchanged, underflow sets.
  - wr when full, no pop: see Optional Feature; overflow sets.
- Sticky flags hold until clr_flags or reset. If clr_flags and a new error event occur on the same edge, the flag stays set (set wins).
- The bus must only pop while pndng=1. The FIFO tolerates violations as above.

Optional Feature:
- Macro: BUS_DRVR_FIFO_DROP_OLDEST_EN.
- Defined: a write while full with no pop drops the oldest entry and accepts the new one. rd_ptr++, write mem[wr_ptr], wr_ptr++, count stays depth, overflow sets.
- Undefined: a write while full with no pop is rejected. No state change except overflow sets, and D_pop is unchanged.

Test Plan (depth=4, pckg_sz=16, almost_full_th=3):
- Reset, then write 0x00A1 -> pndng=0 and D_pop=0x0000 before the edge; after the edge pndng=1, D_pop=0x00A1, count=1.
- Write 0x0001..0x0004 back-to-back -> almost_full=1 after the 3rd write, full=1 and count=4 after the 4th. Then pop 4 times -> D_pop sequence 0x0001,0x0002,0x0003,0x0004, then pndng=0, D_pop=0.
- With the FIFO full (0x0001..0x0004), apply wr_en=1 with 0x0005 and pop=1 together -> count=4, D_pop=0x0002, overflow=0. Popping on through the wrap point yields 0x0002..0x0005.
- Full FIFO, write 0x00FF with no pop -> overflow=1. Without the macro, D_pop stays 0x0001 and the drained data is 0x0001..0x0004. With the macro, D_pop=0x0002 and the drained data is 0x0002,0x0003,0x0004,0x00FF.
- On an empty FIFO, pop=1 -> underflow=1, count=0. Same-cycle wr 0x0BEE plus pop on empty -> count=1, D_pop=0x0BEE. Then clr_flags=1 -> underflow=0 after the edge.
- With count=3, assert reset asynchronously between edges -> pndng, count, full and D_pop go to 0 immediately, without waiting for a clock edge.
